// File: rtl/oc8051_cxrom_arb.sv
// ---------------------------------------------------------------------------
// oc8051_cxrom_arb
//   Two-port arbiter/sequencer for a single combinational 32-bit code-ROM
//   read port. Port 0 is the CPU instruction fetch, port 1 is the MOVC/debug
//   reader. Each request is granted round-robin and its address registered
//   onto rom_addr. WAIT_CYCLES wait states then elapse, the word is captured,
//   and it is returned with a one-cycle ack. A request whose 4-byte window
//   reaches past ROM_SIZE returns err=1 and data=0.
//
//   Optional build macro: OC8051_CXROM_ARB_STATS_EN
//     Adds the p0_grants, p1_grants and err_count statistics outputs.
//
//   Reset: rst is asynchronous and active-low.
// ---------------------------------------------------------------------------
module oc8051_cxrom_arb #(
    parameter int ROM_SIZE    = 10000,  // populated bytes, 1..65536
    parameter int WAIT_CYCLES = 0       // ROM wait states, 0..15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_stb,
    input  logic [15:0] p0_addr,
    output logic        p0_ack,
    output logic [31:0] p0_data,
    output logic        p0_err,

    input  logic        p1_stb,
    input  logic [15:0] p1_addr,
    output logic        p1_ack,
    output logic [31:0] p1_data,
    output logic        p1_err,

    output logic [15:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        busy
`ifdef OC8051_CXROM_ARB_STATS_EN
    ,
    output logic [15:0] p0_grants,
    output logic [15:0] p1_grants,
    output logic [7:0]  err_count
`endif
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;

    // The counter is loaded with WAIT_CYCLES-1, so the FSM stays in WAIT for
    // exactly WAIT_CYCLES cycles. This value is only used when WAIT_CYCLES > 0.
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // 17-bit limit, so a ROM_SIZE of 65536 is representable.
    localparam logic [16:0] ROM_LIMIT = 17'(ROM_SIZE);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]  state_reg;
    logic [3:0]  wait_cnt_reg;
    logic        owner_reg;       // port that owns the current transaction
    logic        last_grant_reg;  // most recent winner; the other port wins a tie
    logic [15:0] rom_addr_reg;

    // -----------------------------------------------------------------------
    // Request gathering and arbitration
    // -----------------------------------------------------------------------
    logic [1:0]  stb_vec;
    logic [15:0] addr_arr [2];
    logic        grant_fire;
    logic        grant_port;
    logic [15:0] grant_addr;
    logic        capture;
    logic [16:0] window_end;
    logic        window_err;

    assign stb_vec     = {p1_stb, p0_stb};
    assign addr_arr[0] = p0_addr;
    assign addr_arr[1] = p1_addr;

    // Pick a winner: a lone requester wins outright; on a tie, the port that
    // was not granted last time wins, which makes contention alternate strictly.
    always_comb begin
        grant_port = 1'b0;
        if (stb_vec == 2'b11) begin
            grant_port = ~last_grant_reg;
        end else if (stb_vec[1]) begin
            grant_port = 1'b1;
        end
    end

    assign grant_fire = (state_reg == ST_IDLE) && (|stb_vec);
    assign grant_addr = addr_arr[grant_port];
    assign capture    = (state_reg == ST_CAPT);

    // The window end is computed with one extra bit, so 0xFFFD..0xFFFF cannot
    // wrap back into range; any window touching ROM_SIZE or above is an error.
    assign window_end = {1'b0, rom_addr_reg} + 17'd3;
    assign window_err = (window_end >= ROM_LIMIT);

    // -----------------------------------------------------------------------
    // Sequencer: IDLE -> (WAIT) -> CAPT -> IDLE
    // -----------------------------------------------------------------------
    // Grant, hold the address through the wait states, then return to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            wait_cnt_reg   <= 4'd0;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            rom_addr_reg   <= 16'h0000;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_fire) begin
                        rom_addr_reg   <= grant_addr;
                        owner_reg      <= grant_port;
                        last_grant_reg <= grant_port;
                        if (WAIT_CYCLES > 0) begin
                            state_reg    <= ST_WAIT;
                            wait_cnt_reg <= WAIT_LOAD;
                        end else begin
                            state_reg <= ST_CAPT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        state_reg <= ST_CAPT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                ST_CAPT: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr = rom_addr_reg;
    assign busy     = (state_reg == ST_WAIT) || (state_reg == ST_CAPT);

    // -----------------------------------------------------------------------
    // Per-port response registers
    // -----------------------------------------------------------------------
    logic        ack_arr  [2];
    logic        err_arr  [2];
    logic [31:0] data_arr [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic        ack_reg;
            logic        err_reg;
            logic [31:0] data_reg;
            logic        hit;

            assign hit = capture && (owner_reg == 1'(gi));

            // Only the owner captures: ack and err pulse for one cycle, and
            // data holds until this port's next ack. Out-of-range words are
            // replaced by zero, so undefined ROM bytes never reach data_reg.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ack_reg  <= 1'b0;
                    err_reg  <= 1'b0;
                    data_reg <= 32'h0000_0000;
                end else begin
                    ack_reg <= hit;
                    err_reg <= hit ? window_err : 1'b0;
                    if (hit) begin
                        data_reg <= window_err ? 32'h0000_0000 : rom_data;
                    end
                end
            end

            assign ack_arr[gi]  = ack_reg;
            assign err_arr[gi]  = err_reg;
            assign data_arr[gi] = data_reg;
        end
    endgenerate

    assign p0_ack  = ack_arr[0];
    assign p0_err  = err_arr[0];
    assign p0_data = data_arr[0];
    assign p1_ack  = ack_arr[1];
    assign p1_err  = err_arr[1];
    assign p1_data = data_arr[1];

`ifdef OC8051_CXROM_ARB_STATS_EN
    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
    logic [15:0] p0_grants_reg;
    logic [15:0] p1_grants_reg;
    logic [7:0]  err_count_reg;

    // Grant counters wrap; the error counter sticks at 0xFF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_grants_reg <= 16'h0000;
            p1_grants_reg <= 16'h0000;
            err_count_reg <= 8'h00;
        end else begin
            if (grant_fire) begin
                if (grant_port) begin
                    p1_grants_reg <= p1_grants_reg + 16'd1;
                end else begin
                    p0_grants_reg <= p0_grants_reg + 16'd1;
                end
            end
            if (capture && window_err && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    assign p0_grants = p0_grants_reg;
    assign p1_grants = p1_grants_reg;
    assign err_count = err_count_reg;
`endif

endmodule
